// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU definitions: fetch FSM encoding, halt encoding and the NOP used to
// fill pipeline bubbles. Also imported by the branch unit and decoder.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
// Flush inserts a bubble, load captures a fetched instruction, otherwise it holds.
module if_id_reg
    import pc_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (i_flush) begin
            instr_d = NOP_INSTR;
            pc_d    = 32'h0;
            valid_d = 1'b0;
        end else if (i_load) begin
            instr_d = i_instr;
            pc_d    = i_pc;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign o_instr = instr_q;
    assign o_pc    = pc_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, IDLE/RUN/HALT control, advance counter,
// and the IF/ID register fed from combinational instruction memory.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_stall,
    input  logic        i_taken,
    input  logic [31:0] i_target,
    input  logic [31:0] i_instr,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_valid,
    output logic        o_halted,
    output logic [31:0] o_cycles
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  cycles_q, cycles_d;
    logic [31:0]  pc_plus1;
    logic         advance;
    logic         ifid_load;
    logic         ifid_flush;

    assign pc_plus1 = pc_q + 32'd1;
    assign advance  = (state_q == FETCH_RUN) && i_enable && !i_stall;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cycles_d   = cycles_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (i_enable) begin
                    state_d = FETCH_RUN;
                end
            end
            FETCH_RUN: begin
                if (advance) begin
                    cycles_d = cycles_q + 32'd1;
                    // A taken redirect wins over a halt word: that fetch was wrong-path.
                    if (i_taken) begin
                        pc_d       = i_target;
                        ifid_flush = 1'b1;
                    end else if (i_instr == HALT_WORD) begin
                        ifid_load = 1'b1;
                        state_d   = FETCH_HALT;
                    end else begin
                        pc_d      = pc_plus1;
                        ifid_load = 1'b1;
                    end
                end
            end
            FETCH_HALT: begin
                // Let the halt word drain out of IF/ID; nothing else moves.
                if (i_enable && !i_stall) begin
                    ifid_flush = 1'b1;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= FETCH_IDLE;
            pc_q     <= RESET_PC;
            cycles_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cycles_q <= cycles_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (ifid_load),
        .i_flush (ifid_flush),
        .i_instr (i_instr),
        .i_pc    (pc_plus1),
        .o_instr (o_instr),
        .o_pc    (o_pc),
        .o_valid (o_valid)
    );

    assign o_imem_addr = pc_q;
    assign o_halted    = (state_q == FETCH_HALT);
    assign o_cycles    = cycles_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector bench for pc_fetch_unit: a table of per-cycle controls with
// hand-computed outputs, plus short sequences for wrap-around and address isolation.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT, RESET_PC = 0
    logic        rst, i_enable, i_stall, i_taken;
    logic [31:0] i_target, i_instr;
    logic [31:0] o_imem_addr, o_instr, o_pc, o_cycles;
    logic        o_valid, o_halted;
    logic        halt_en;

    // Memory model: imem[k] = k + 0x100, optionally imem[3] = halt word
    assign i_instr = (halt_en && o_imem_addr == 32'd3) ? 32'hFFFF_FFFF
                                                        : o_imem_addr + 32'h100;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_stall(i_stall),
        .i_taken(i_taken), .i_target(i_target), .i_instr(i_instr),
        .o_imem_addr(o_imem_addr), .o_instr(o_instr), .o_pc(o_pc),
        .o_valid(o_valid), .o_halted(o_halted), .o_cycles(o_cycles)
    );

    // Second DUT for PC wrap-around
    logic        rst2, en2;
    logic [31:0] instr2, addr2, oinstr2, opc2, cycles2;
    logic        valid2, halted2;
    assign instr2 = addr2 + 32'h100;

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut2 (
        .clk(clk), .rst(rst2), .i_enable(en2), .i_stall(1'b0),
        .i_taken(1'b0), .i_target(32'h0), .i_instr(instr2),
        .o_imem_addr(addr2), .o_instr(oinstr2), .o_pc(opc2),
        .o_valid(valid2), .o_halted(halted2), .o_cycles(cycles2)
    );

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        stall;
        logic        taken;
        logic [31:0] target;
        logic        halt;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_halted;
        logic [31:0] e_cycles;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs[NV];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=0x%08h required=0x%08h", name, idx, act, exp);
        end
    endtask

    initial begin
        //                rst en st tk target       hlt addr          instr          pc          v  h  cyc
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,  32'h0,        32'h0,  1'b0,1'b0,32'd0};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h0,  32'h0,        32'h0,  1'b0,1'b0,32'd0};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h1,  32'h100,      32'h1,  1'b1,1'b0,32'd1};
        vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h2,  32'h101,      32'h2,  1'b1,1'b0,32'd2};
        vecs[4]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h3,  32'h102,      32'h3,  1'b1,1'b0,32'd3};
        vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h4,  32'h103,      32'h4,  1'b1,1'b0,32'd4};
        vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h5,  32'h104,      32'h5,  1'b1,1'b0,32'd5};
        // redirect to 0x40 at PC=5
        vecs[7]  = '{1'b1,1'b1,1'b0,1'b1,32'h40, 1'b0,32'h40, 32'h0,        32'h0,  1'b0,1'b0,32'd6};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h41, 32'h140,      32'h41, 1'b1,1'b0,32'd7};
        // disabled: taken ignored, everything frozen
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,32'h99, 1'b0,32'h41, 32'h140,      32'h41, 1'b1,1'b0,32'd7};
        vecs[10] = '{1'b1,1'b1,1'b0,1'b1,32'h7,  1'b0,32'h7,  32'h0,        32'h0,  1'b0,1'b0,32'd8};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h8,  32'h107,      32'h8,  1'b1,1'b0,32'd9};
        // stall + taken at PC=8 for two cycles
        vecs[12] = '{1'b1,1'b1,1'b1,1'b1,32'h77, 1'b0,32'h8,  32'h107,      32'h8,  1'b1,1'b0,32'd9};
        vecs[13] = '{1'b1,1'b1,1'b1,1'b1,32'h77, 1'b0,32'h8,  32'h107,      32'h8,  1'b1,1'b0,32'd9};
        vecs[14] = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h9,  32'h108,      32'h9,  1'b1,1'b0,32'd10};
        // reset mid-run, then halt word at address 3
        vecs[15] = '{1'b0,1'b1,1'b0,1'b1,32'h55, 1'b1,32'h0,  32'h0,        32'h0,  1'b0,1'b0,32'd0};
        vecs[16] = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1,32'h0,  32'h0,        32'h0,  1'b0,1'b0,32'd0};
        vecs[17] = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1,32'h1,  32'h100,      32'h1,  1'b1,1'b0,32'd1};
        vecs[18] = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1,32'h2,  32'h101,      32'h2,  1'b1,1'b0,32'd2};
        vecs[19] = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1,32'h3,  32'h102,      32'h3,  1'b1,1'b0,32'd3};
        vecs[20] = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1,32'h3,  32'hFFFF_FFFF,32'h4,  1'b1,1'b1,32'd4};
        vecs[21] = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1,32'h3,  32'h0,        32'h0,  1'b0,1'b1,32'd4};
        vecs[22] = '{1'b1,1'b1,1'b0,1'b1,32'h50, 1'b1,32'h3,  32'h0,        32'h0,  1'b0,1'b1,32'd4};
        // reset during HALT
        vecs[23] = '{1'b0,1'b1,1'b0,1'b0,32'h0,  1'b1,32'h0,  32'h0,        32'h0,  1'b0,1'b0,32'd0};
        vecs[24] = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1,32'h0,  32'h0,        32'h0,  1'b0,1'b0,32'd0};
        vecs[25] = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1,32'h1,  32'h100,      32'h1,  1'b1,1'b0,32'd1};
        vecs[26] = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1,32'h2,  32'h101,      32'h2,  1'b1,1'b0,32'd2};
        vecs[27] = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1,32'h3,  32'h102,      32'h3,  1'b1,1'b0,32'd3};
        // halt word fetched under a taken branch: flushed, no halt
        vecs[28] = '{1'b1,1'b1,1'b0,1'b1,32'h10, 1'b1,32'h10, 32'h0,        32'h0,  1'b0,1'b0,32'd4};
        vecs[29] = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1,32'h11, 32'h110,      32'h11, 1'b1,1'b0,32'd5};

        rst = 1'b0; i_enable = 1'b0; i_stall = 1'b0; i_taken = 1'b0;
        i_target = 32'h0; halt_en = 1'b0;
        rst2 = 1'b0; en2 = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst      = vecs[i].rst_n;
            i_enable = vecs[i].en;
            i_stall  = vecs[i].stall;
            i_taken  = vecs[i].taken;
            i_target = vecs[i].target;
            halt_en  = vecs[i].halt;
            @(posedge clk);
            #1;
            check("imem_addr", i, o_imem_addr, vecs[i].e_addr);
            check("instr",     i, o_instr,     vecs[i].e_instr);
            check("pc",        i, o_pc,        vecs[i].e_pc);
            check("valid",     i, {31'h0, o_valid},  {31'h0, vecs[i].e_valid});
            check("halted",    i, {31'h0, o_halted}, {31'h0, vecs[i].e_halted});
            check("cycles",    i, o_cycles,    vecs[i].e_cycles);
            $display("step %0d: addr=0x%08h instr=0x%08h pc=0x%08h valid=%0b halted=%0b cycles=%0d",
                     i, o_imem_addr, o_instr, o_pc, o_valid, o_halted, o_cycles);
        end

        // Changing inputs mid-cycle must not move o_imem_addr (PC at 0x11 now)
        @(negedge clk);
        i_taken  = 1'b1;
        i_target = 32'h99;
        i_stall  = 1'b1;
        #1;
        check("addr_isolated", 100, o_imem_addr, 32'h11);
        i_stall  = 1'b0;
        #1;
        check("addr_isolated", 101, o_imem_addr, 32'h11);
        i_taken  = 1'b0;
        $display("isolation: addr=0x%08h", o_imem_addr);

        // Wrap-around from RESET_PC = 0xFFFF_FFFF
        begin
            logic        r2[4];
            logic [31:0] ea[4], ei[4], ep[4];
            r2 = '{1'b0, 1'b1, 1'b1, 1'b1};
            ea = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1};
            ei = '{32'h0, 32'h0, 32'h0000_00FF, 32'h100};
            ep = '{32'h0, 32'h0, 32'h0, 32'h1};
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                rst2 = r2[k];
                en2  = 1'b1;
                @(posedge clk);
                #1;
                check("wrap_addr",  200 + k, addr2,   ea[k]);
                check("wrap_instr", 200 + k, oinstr2, ei[k]);
                check("wrap_pc",    200 + k, opc2,    ep[k]);
                $display("wrap %0d: addr=0x%08h instr=0x%08h pc=0x%08h", k, addr2, oinstr2, opc2);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
